binning_k: RTL and testbench



---
 rtl/binning_pkg.sv | 14 +
 rtl/bin_row_accumulator.sv | 61 ++++++
 rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv | 59 +++++
 rtl/binning_k.sv | 163 ++++++++++++++++
 tb/tb_binning_k.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/binning_pkg.sv
// rtl/binning_pkg.sv - shared types and width helpers for the K x K pixel binner
package binning_pkg;

    typedef enum logic {
        BIN_AVERAGE   = 1'b0,
        BIN_THRESHOLD = 1'b1
    } bin_mode_t;

    // Window sum width: a full K x K window of maximum pixels must fit without overflow.
    function automatic int sum_width(input int data_width, input int kernel_size);
        return data_width + 2 * $clog2(kernel_size);
    endfunction

endpackage

// File: rtl/bin_row_accumulator.sv
// rtl/bin_row_accumulator.sv - horizontal K-pixel sum with group-close strobe and band tracking
module bin_row_accumulator
    import binning_pkg::*;
#(
    parameter  int HRES        = 1280,
    parameter  int VRES        = 720,
    parameter  int DATA_WIDTH  = 8,
    parameter  int KERNEL_SIZE = 4,
    localparam int LOGK        = $clog2(KERNEL_SIZE),
    localparam int HWIDTH      = $clog2(HRES),
    localparam int VWIDTH      = $clog2(VRES),
    localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, KERNEL_SIZE)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [HWIDTH-1:0]        i_hcount,
    input  logic [VWIDTH-1:0]        i_vcount,
    input  logic [DATA_WIDTH-1:0]    i_pixel,
    input  logic                     i_valid,
    output logic                     o_close,
    output logic [SUM_WIDTH-1:0]     o_hsum,
    output logic [HWIDTH-LOGK-1:0]   o_addr,
    output logic [LOGK-1:0]          o_phase,
    output logic [VWIDTH-LOGK-1:0]   o_vbin,
    output logic                     o_armed
);

    localparam logic [LOGK-1:0] POS_LAST = LOGK'(KERNEL_SIZE - 1);

    logic [SUM_WIDTH-1:0] r_hsum;
    logic                 r_armed;
    logic [LOGK-1:0]      w_hpos;
    logic [SUM_WIDTH-1:0] w_pixel_ext;
    logic [SUM_WIDTH-1:0] w_hsum;

    assign w_hpos      = i_hcount[LOGK-1:0];
    assign w_pixel_ext = SUM_WIDTH'(i_pixel);
    assign w_hsum      = (w_hpos == '0) ? w_pixel_ext : (r_hsum + w_pixel_ext);

    assign o_close = i_valid && (w_hpos == POS_LAST);
    assign o_hsum  = w_hsum;
    assign o_addr  = i_hcount[HWIDTH-1:LOGK];
    assign o_phase = i_vcount[LOGK-1:0];
    assign o_vbin  = i_vcount[VWIDTH-1:LOGK];
    assign o_armed = r_armed;

    // Running horizontal sum; the first pixel of each group restarts it.
    always_ff @(posedge clk_in) begin
        if (rst_in)       r_hsum <= '0;
        else if (i_valid) r_hsum <= w_hsum;
    end

    // A band may emit only once its first row started cleanly after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_armed <= 1'b0;
        else if (i_valid && (i_hcount == '0) && (i_vcount[LOGK-1:0] == '0))
            r_armed <= 1'b1;
    end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv - true dual-port read-first block RAM, single clock
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_ram_data_a;
    logic [RAM_WIDTH-1:0] r_ram_data_b;

    // Both ports share one array; each read returns the contents from before that cycle's write.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) r_mem[addra] <= dina;
            r_ram_data_a <= r_mem[addra];
        end
        if (enb) begin
            if (web) r_mem[addrb] <= dinb;
            r_ram_data_b <= r_mem[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign douta = r_ram_data_a;
            assign doutb = r_ram_data_b;
        end else begin : g_output_register
            logic [RAM_WIDTH-1:0] r_douta;
            logic [RAM_WIDTH-1:0] r_doutb;
            // Optional output register stage, giving two cycles of read latency.
            always_ff @(posedge clka) begin
                if (rsta)        r_douta <= '0;
                else if (regcea) r_douta <= r_ram_data_a;
                if (rstb)        r_doutb <= '0;
                else if (regceb) r_doutb <= r_ram_data_b;
            end
            assign douta = r_douta;
            assign doutb = r_doutb;
        end
    endgenerate

endmodule

// File: rtl/binning_k.sv
// rtl/binning_k.sv - K x K pixel binner with column-sum BRAM and average/threshold reduction
module binning_k
    import binning_pkg::*;
#(
    parameter  int HRES        = 1280,
    parameter  int VRES        = 720,
    parameter  int DATA_WIDTH  = 8,
    parameter  int KERNEL_SIZE = 4,
    localparam int LOGK        = $clog2(KERNEL_SIZE),
    localparam int HWIDTH      = $clog2(HRES),
    localparam int VWIDTH      = $clog2(VRES),
    localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, KERNEL_SIZE)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [HWIDTH-1:0]        hcount_in,
    input  logic [VWIDTH-1:0]        vcount_in,
    input  logic [DATA_WIDTH-1:0]    pixel_data_in,
    input  logic                     data_valid_in,
    input  logic                     mode_in,
    input  logic [SUM_WIDTH-1:0]     threshold_in,
    output logic [DATA_WIDTH-1:0]    pixel_data_out,
    output logic [HWIDTH-LOGK-1:0]   hcount_out,
    output logic [VWIDTH-LOGK-1:0]   vcount_out,
    output logic                     data_valid_out
);

    localparam int              AW         = HWIDTH - LOGK;
    localparam int              VBW        = VWIDTH - LOGK;
    localparam logic [LOGK-1:0] PHASE_LAST = LOGK'(KERNEL_SIZE - 1);

    logic                 w_close;
    logic [SUM_WIDTH-1:0] w_hsum;
    logic [AW-1:0]        w_addr;
    logic [LOGK-1:0]      w_phase;
    logic [VBW-1:0]       w_vbin;
    logic                 w_armed;
    logic [SUM_WIDTH-1:0] w_stored;
    logic [SUM_WIDTH-1:0] w_total;
    logic [SUM_WIDTH-1:0] w_wdata;
    logic                 w_write;
    logic                 w_emit;

    bin_mode_t            r_mode;
    logic [SUM_WIDTH-1:0] r_thr;
    logic                 r_s1_vld, r_s2_vld;
    logic [SUM_WIDTH-1:0] r_s1_hsum, r_s2_hsum;
    logic [AW-1:0]        r_s1_addr, r_s2_addr;
    logic [LOGK-1:0]      r_s1_phase, r_s2_phase;
    logic [VBW-1:0]       r_s1_vbin, r_s2_vbin;
    logic                 r_s1_armed, r_s2_armed;
    bin_mode_t            r_s1_mode, r_s2_mode;
    logic [SUM_WIDTH-1:0] r_s1_thr, r_s2_thr;

    bin_row_accumulator #(
        .HRES        (HRES),
        .VRES        (VRES),
        .DATA_WIDTH  (DATA_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_row_acc (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_hcount (hcount_in),
        .i_vcount (vcount_in),
        .i_pixel  (pixel_data_in),
        .i_valid  (data_valid_in),
        .o_close  (w_close),
        .o_hsum   (w_hsum),
        .o_addr   (w_addr),
        .o_phase  (w_phase),
        .o_vbin   (w_vbin),
        .o_armed  (w_armed)
    );

    // Read on the close cycle (port B), write back two cycles later (port A).
    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (SUM_WIDTH),
        .RAM_DEPTH       (HRES / KERNEL_SIZE),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_colsum_ram (
        .addra  (r_s2_addr),
        .addrb  (w_addr),
        .dina   (w_wdata),
        .dinb   ('0),
        .clka   (clk_in),
        .wea    (w_write),
        .web    (1'b0),
        .ena    (1'b1),
        .enb    (w_close),
        .rsta   (1'b0),
        .rstb   (rst_in),
        .regcea (1'b0),
        .regceb (1'b1),
        .douta  (),
        .doutb  (w_stored)
    );

    assign w_total = w_stored + r_s2_hsum;
    assign w_wdata = (r_s2_phase == '0) ? r_s2_hsum : w_total;
    assign w_write = r_s2_vld && (r_s2_phase != PHASE_LAST);
    assign w_emit  = r_s2_vld && (r_s2_phase == PHASE_LAST) && r_s2_armed;

    // Frame-wide reduction settings, captured on the first pixel of the frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mode <= BIN_AVERAGE;
            r_thr  <= '0;
        end else if (data_valid_in && (hcount_in == '0) && (vcount_in == '0)) begin
            r_mode <= bin_mode_t'(mode_in);
            r_thr  <= threshold_in;
        end
    end

    // Close-event valids travelling alongside the BRAM read latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_close;
            r_s2_vld <= r_s1_vld;
        end
    end

    // Close-event payload; settings travel too so a frame's last windows keep their mode.
    always_ff @(posedge clk_in) begin
        r_s1_hsum  <= w_hsum;
        r_s1_addr  <= w_addr;
        r_s1_phase <= w_phase;
        r_s1_vbin  <= w_vbin;
        r_s1_armed <= w_armed;
        r_s1_mode  <= r_mode;
        r_s1_thr   <= r_thr;
        r_s2_hsum  <= r_s1_hsum;
        r_s2_addr  <= r_s1_addr;
        r_s2_phase <= r_s1_phase;
        r_s2_vbin  <= r_s1_vbin;
        r_s2_armed <= r_s1_armed;
        r_s2_mode  <= r_s1_mode;
        r_s2_thr   <= r_s1_thr;
    end

    // Reduce the completed window and register it; outputs hold between strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_valid_out <= 1'b0;
            pixel_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            data_valid_out <= w_emit;
            if (w_emit) begin
                if (r_s2_mode == BIN_THRESHOLD)
                    pixel_data_out <= {DATA_WIDTH{(w_total > r_s2_thr)}};
                else
                    pixel_data_out <= w_total[SUM_WIDTH-1 -: DATA_WIDTH];
                hcount_out <= r_s2_addr;
                vcount_out <= r_s2_vbin;
            end
        end
    end

endmodule

// File: tb/tb_binning_k.sv
// tb/tb_binning_k.sv - scoreboard bench for binning_k with directed frames
module tb_binning_k;

    localparam int HRES = 16;
    localparam int VRES = 10;
    localparam int DW   = 8;
    localparam int K    = 4;
    localparam int HW   = 4;
    localparam int VW   = 4;
    localparam int SW   = 12;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [HW-1:0] hcount_in = '0;
    logic [VW-1:0] vcount_in = '0;
    logic [DW-1:0] pixel_data_in = '0;
    logic          data_valid_in = 1'b0;
    logic          mode_in = 1'b0;
    logic [SW-1:0] threshold_in = '0;
    logic [DW-1:0] pixel_data_out;
    logic [HW-3:0] hcount_out;
    logic [VW-3:0] vcount_out;
    logic          data_valid_out;

    binning_k #(
        .HRES        (HRES),
        .VRES        (VRES),
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (K)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .pixel_data_in  (pixel_data_in),
        .data_valid_in  (data_valid_in),
        .mode_in        (mode_in),
        .threshold_in   (threshold_in),
        .pixel_data_out (pixel_data_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int data;
        int hb;
        int vb;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    int   fr [VRES][HRES];
    bit   m_mode  = 1'b0;
    int   m_thr   = 0;
    bit   m_armed = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every strobe pops one expectation from the scoreboard.
    always @(negedge clk_in) begin
        if (data_valid_out) begin
            n_out++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data=%0d h=%0d v=%0d expected no strobe",
                         pixel_data_out, hcount_out, vcount_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pixel_data_out", int'(pixel_data_out), e.data);
                check("hcount_out", int'(hcount_out), e.hb);
                check("vcount_out", int'(vcount_out), e.vb);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle();
        data_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic pixel(input int h, input int v);
        int sum;
        int d;
        hcount_in     = HW'(h);
        vcount_in     = VW'(v);
        pixel_data_in = DW'(fr[v][h]);
        data_valid_in = 1'b1;
        if (h == 0 && v == 0) begin
            m_mode = mode_in;
            m_thr  = int'(threshold_in);
        end
        if (h == 0 && (v % K) == 0) m_armed = 1'b1;
        if ((h % K) == K - 1 && (v % K) == K - 1 && m_armed) begin
            sum = 0;
            for (int dv = 0; dv < K; dv++)
                for (int dh = 0; dh < K; dh++)
                    sum += fr[v - K + 1 + dv][h - K + 1 + dh];
            d = m_mode ? ((sum > m_thr) ? 255 : 0) : (sum / (K * K));
            q.push_back('{d, h / K, v / K, cyc + 3});
        end
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
    endtask

    // Settings differ from the frame's own after (0,0) so a late latch would show.
    task automatic send_frame(input bit md, input int thr, input bit gaps, input int rst_v);
        for (int v = 0; v < VRES; v++) begin
            for (int h = 0; h < HRES; h++) begin
                if (gaps) while ($urandom_range(0, 1) == 1) idle();
                if (v == rst_v && h == 6) begin
                    rst_in        = 1'b1;
                    data_valid_in = 1'b0;
                    m_mode        = 1'b0;
                    m_thr         = 0;
                    m_armed       = 1'b0;
                    @(posedge clk_in);
                    #1;
                    rst_in = 1'b0;
                    check("midframe_reset_valid", int'(data_valid_out), 0);
                    check("midframe_reset_pixel", int'(pixel_data_out), 0);
                end
                mode_in      = (v == 0 && h == 0) ? md : ~md;
                threshold_in = (v == 0 && h == 0) ? SW'(thr) : SW'($urandom_range(0, 4095));
                pixel(h, v);
            end
        end
    endtask

    task automatic fill_const(input int val);
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++)
                fr[v][h] = val;
    endtask

    task automatic fill_rand();
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++)
                fr[v][h] = $urandom_range(0, 255);
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("reset_valid", int'(data_valid_out), 0);
        check("reset_pixel", int'(pixel_data_out), 0);
        check("reset_hcount", int'(hcount_out), 0);
        check("reset_vcount", int'(vcount_out), 0);

        // Constant frame: every window averages back to 100, two bands of four.
        fill_const(100);
        n0 = n_out;
        send_frame(1'b0, 0, 1'b0, -1);
        repeat (6) idle();
        check("frame_a_strobe_count", n_out - n0, (VRES / K) * (HRES / K));

        // Random frame with a near-saturated first window (15*255 >> 4 = 239).
        fill_rand();
        for (int v = 0; v < K; v++)
            for (int h = 0; h < K; h++)
                fr[v][h] = 255;
        fr[0][0] = 0;
        send_frame(1'b0, 0, 1'b0, -1);

        // Threshold frame: window (0,0) sums to 1601 (above), the rest to 1600 (not above).
        fill_const(100);
        fr[0][0] = 101;
        send_frame(1'b1, 1600, 1'b0, -1);

        // Random data with random idle gaps between valid pixels.
        fill_rand();
        send_frame(1'b0, 0, 1'b1, -1);

        // One-cycle reset in row 2 of band 0: band 0 silent, band 1 correct.
        fill_rand();
        n0 = n_out;
        send_frame(1'b0, 0, 1'b0, 2);
        repeat (6) idle();
        check("reset_frame_strobe_count", n_out - n0, HRES / K);

        // Random threshold frame restarted without reset.
        fill_rand();
        send_frame(1'b1, 2040, 1'b1, -1);

        repeat (8) idle();
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
